// File: rtl/silife_grid_engine_pkg.sv
// Shared definitions for the SiLife grid engine: FSM state encoding and the
// default grid geometry used by the engine and its row-rule helper.
package silife_grid_engine_pkg;

    localparam int DEFAULT_ROWS = 32;
    localparam int DEFAULT_COLS = 8;
    localparam int GEN_WIDTH    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

endpackage

// File: rtl/silife_grid_engine_row_rule.sv
// Combinational Game-of-Life rule for one row. Given the rows above (prev),
// at (cur) and below (nxt), produce the next-generation value of cur.
// Columns beyond the row ends wrap around when WRAP is set, otherwise read dead.
module silife_row_rule
    import silife_grid_engine_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter bit WRAP = 1'b1
)(
    input  logic [COLS-1:0] i_prevRow,
    input  logic [COLS-1:0] i_curRow,
    input  logic [COLS-1:0] i_nxtRow,
    output logic [COLS-1:0] o_nextRow
);

    // Each row is padded with one cell on both sides: index c+1 is column c,
    // index 0 is the column left of 0 and index COLS+1 the column right of COLS-1.
    logic [COLS+1:0] w_prevExt;
    logic [COLS+1:0] w_curExt;
    logic [COLS+1:0] w_nxtExt;

    assign w_prevExt = {(WRAP ? i_prevRow[0] : 1'b0), i_prevRow, (WRAP ? i_prevRow[COLS-1] : 1'b0)};
    assign w_curExt  = {(WRAP ? i_curRow[0]  : 1'b0), i_curRow,  (WRAP ? i_curRow[COLS-1]  : 1'b0)};
    assign w_nxtExt  = {(WRAP ? i_nxtRow[0]  : 1'b0), i_nxtRow,  (WRAP ? i_nxtRow[COLS-1]  : 1'b0)};

    // Count the eight neighbours of every column and apply birth-on-3 / survive-on-2.
    always_comb begin : ruleLoop
        logic [3:0] w_count;
        w_count   = '0;
        o_nextRow = '0;
        for (int c = 0; c < COLS; c++) begin
            w_count = 4'(w_prevExt[c]) + 4'(w_prevExt[c+1]) + 4'(w_prevExt[c+2])
                    + 4'(w_curExt[c])                       + 4'(w_curExt[c+2])
                    + 4'(w_nxtExt[c])  + 4'(w_nxtExt[c+1])  + 4'(w_nxtExt[c+2]);
            o_nextRow[c] = (w_count == 4'd3) || (i_curRow[c] && (w_count == 4'd2));
        end
    end

endmodule

// File: rtl/silife_grid_engine.sv
// SiLife cell store and generation engine. Holds a ROWS x COLS grid in flops,
// accepts row writes while idle and, on a step request, rewrites the grid in
// place one row per cycle through a prev/cur/nxt window. Row 0's original
// value is saved up front because it is overwritten before the last row needs it.
module silife_grid_engine
    import silife_grid_engine_pkg::*;
#(
    parameter  int ROWS = DEFAULT_ROWS,
    parameter  int COLS = DEFAULT_COLS,
    parameter  bit WRAP = 1'b1,
    localparam int RW   = $clog2(ROWS)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_wrEn,
    input  logic [RW-1:0]        i_rowSelect,
    input  logic [COLS-1:0]      i_cellsIn,
    input  logic                 i_step,
    input  logic [RW-1:0]        i_rdRow,
    output logic [COLS-1:0]      o_rdCells,
    output logic                 o_busy,
    output logic [GEN_WIDTH-1:0] o_generation
);

    state_t                r_state;
    logic [RW-1:0]         r_rowPtr;
    logic [COLS-1:0]       r_prevRow;
    logic [COLS-1:0]       r_curRow;
    logic [COLS-1:0]       r_row0Save;
    logic [COLS-1:0]       r_mem [ROWS];
    logic [GEN_WIDTH-1:0]  r_generation;
    logic                  r_busy;

    logic                  w_lastRow;
    logic [RW-1:0]         w_rowPtrInc;
    logic [COLS-1:0]       w_nxtRow;
    logic [COLS-1:0]       w_newRow;

    assign w_lastRow   = (r_rowPtr == RW'(ROWS - 1));
    assign w_rowPtrInc = r_rowPtr + RW'(1);
    assign w_nxtRow    = w_lastRow ? (WRAP ? r_row0Save : '0) : r_mem[w_rowPtrInc];

    silife_row_rule #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_rowRule (
        .i_prevRow (r_prevRow),
        .i_curRow  (r_curRow),
        .i_nxtRow  (w_nxtRow),
        .o_nextRow (w_newRow)
    );

    // Control FSM, grid store and sweep window; everything freezes while i_en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rowPtr     <= '0;
            r_prevRow    <= '0;
            r_curRow     <= '0;
            r_row0Save   <= '0;
            r_generation <= '0;
            r_busy       <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_wrEn) begin
                        r_mem[i_rowSelect] <= i_cellsIn;
                    end else if (i_step) begin
                        r_state <= ST_PRIME;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    r_prevRow  <= WRAP ? r_mem[ROWS-1] : '0;
                    r_curRow   <= r_mem[0];
                    r_row0Save <= r_mem[0];
                    r_rowPtr   <= '0;
                    r_state    <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    r_mem[r_rowPtr] <= w_newRow;
                    r_prevRow       <= r_curRow;
                    r_curRow        <= w_nxtRow;
                    r_rowPtr        <= w_rowPtrInc;
                    if (w_lastRow) begin
                        r_rowPtr     <= '0;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_generation <= r_generation + GEN_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdCells    = r_mem[i_rdRow];
    assign o_busy       = r_busy;
    assign o_generation = r_generation;

endmodule

// File: tb/tb_silife_grid_engine.sv
// Self-checking bench for silife_grid_engine. Two instances (torus and bounded)
// share stimulus; a vector table covers still lifes, oscillators and edge wrap,
// followed by hand-written sequences for collisions, pause, long glider and reset.
module tb_silife_grid_engine;

    localparam int ROWS = 32;
    localparam int COLS = 8;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    typedef struct packed {
        logic       v;
        logic [4:0] row;
        logic [7:0] cells;
    } rowEntry_t;

    typedef struct packed {
        rowEntry_t [2:0] load;
        logic [7:0]      steps;
        rowEntry_t [2:0] expT;
        rowEntry_t [2:0] expB;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wrEn = 1'b0;
    logic       step = 1'b0;
    logic [4:0] rowSelect = '0;
    logic [4:0] rdRow = '0;
    logic [7:0] cellsIn = '0;

    logic [7:0]  rdCellsT, rdCellsB;
    logic        busyT, busyB;
    logic [15:0] genT, genB;

    int checks = 0;
    int errors = 0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    silife_grid_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b1)) dutTorus (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_wrEn(wrEn), .i_rowSelect(rowSelect),
        .i_cellsIn(cellsIn), .i_step(step), .i_rdRow(rdRow),
        .o_rdCells(rdCellsT), .o_busy(busyT), .o_generation(genT)
    );

    silife_grid_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b0)) dutBound (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_wrEn(wrEn), .i_rowSelect(rowSelect),
        .i_cellsIn(cellsIn), .i_step(step), .i_rdRow(rdRow),
        .o_rdCells(rdCellsB), .o_busy(busyB), .o_generation(genB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: count neighbours cell by cell with explicit edge handling.
    function automatic grid_t lifeStep(grid_t g, bit wrap);
        grid_t n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                            cnt += int'(g[rr][cc]);
                        end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                            cnt += int'(g[rr][cc]);
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic rowEntry_t E(input int r, input logic [7:0] c);
        return {1'b1, 5'(r), c};
    endfunction

    function automatic grid_t fromEntries(input rowEntry_t [2:0] e);
        grid_t g;
        g = '0;
        for (int i = 0; i < 3; i++) begin
            if (e[i].v) g[e[i].row] = e[i].cells;
        end
        return g;
    endfunction

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        wrEn = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic writeRow(input logic [4:0] r, input logic [7:0] c);
        wrEn = 1'b1;
        rowSelect = r;
        cellsIn = c;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    // Pulse step and count busy cycles; optionally freeze via en or inject writes/steps mid-sweep.
    task automatic runStep(input int pauseAt, input int injectAt, output int busyCycles);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        busyCycles = 0;
        while ((busyT || busyB) && busyCycles < 200) begin
            busyCycles++;
            if (pauseAt > 0 && busyCycles == pauseAt) en = 1'b0;
            if (pauseAt > 0 && busyCycles == pauseAt + 10) en = 1'b1;
            if (injectAt > 0 && busyCycles == injectAt) begin
                wrEn = 1'b1; rowSelect = 5'd20; cellsIn = 8'hFF; step = 1'b1;
            end
            if (injectAt > 0 && busyCycles == injectAt + 1) begin
                wrEn = 1'b0; step = 1'b0;
            end
            @(negedge clk);
        end
        en = 1'b1; wrEn = 1'b0; step = 1'b0;
        if (busyCycles >= 200) checkOutput("busyTimeout", 32'd1, 32'd0);
    endtask

    task automatic compareGrids(input string tag, input grid_t expT, input grid_t expB);
        for (int r = 0; r < ROWS; r++) begin
            rdRow = 5'(r);
            #1;
            checkOutput($sformatf("%s torus row%0d", tag, r), 32'(rdCellsT), 32'(expT[r]));
            checkOutput($sformatf("%s bound row%0d", tag, r), 32'(rdCellsB), 32'(expB[r]));
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int bc;
        resetDut();
        for (int i = 0; i < 3; i++) begin
            if (v.load[i].v) writeRow(v.load[i].row, v.load[i].cells);
        end
        for (int s = 0; s < int'(v.steps); s++) begin
            runStep(0, 0, bc);
            checkOutput($sformatf("vec%0d busyLen", idx), 32'(bc), 32'd33);
        end
        compareGrids($sformatf("vec%0d", idx), fromEntries(v.expT), fromEntries(v.expB));
        checkOutput($sformatf("vec%0d genT", idx), 32'(genT), 32'(v.steps));
        checkOutput($sformatf("vec%0d genB", idx), 32'(genB), 32'(v.steps));
    endtask

    initial begin
        vec_t  vecs[7];
        rowEntry_t none;
        grid_t gT, gB, g0;
        int    bc, total;
        none = '0;

        // load, steps, expected torus rows, expected bounded rows
        vecs[0] = {{none, none, E(4, 8'h0E)}, 8'd1,
                   {E(3, 8'h04), E(4, 8'h04), E(5, 8'h04)}, {E(3, 8'h04), E(4, 8'h04), E(5, 8'h04)}};
        vecs[1] = {{none, none, E(4, 8'h0E)}, 8'd2,
                   {none, none, E(4, 8'h0E)}, {none, none, E(4, 8'h0E)}};
        vecs[2] = {{none, E(10, 8'h18), E(11, 8'h18)}, 8'd5,
                   {none, E(10, 8'h18), E(11, 8'h18)}, {none, E(10, 8'h18), E(11, 8'h18)}};
        vecs[3] = {{none, none, E(7, 8'h10)}, 8'd1,
                   {none, none, none}, {none, none, none}};
        vecs[4] = {{none, none, E(4, 8'h83)}, 8'd1,
                   {E(3, 8'h01), E(4, 8'h01), E(5, 8'h01)}, {none, none, none}};
        vecs[5] = {{E(31, 8'h08), E(0, 8'h08), E(1, 8'h08)}, 8'd1,
                   {none, none, E(0, 8'h1C)}, {none, none, none}};
        vecs[6] = {{none, E(12, 8'h0C), E(13, 8'h04)}, 8'd1,
                   {none, E(12, 8'h0C), E(13, 8'h0C)}, {none, E(12, 8'h0C), E(13, 8'h0C)}};

        // Reset state
        resetDut();
        checkOutput("reset busyT", 32'(busyT), 32'd0);
        checkOutput("reset busyB", 32'(busyB), 32'd0);
        checkOutput("reset genT", 32'(genT), 32'd0);
        compareGrids("reset", '0, '0);

        // en low: write and step ignored while idle
        en = 1'b0;
        wrEn = 1'b1; rowSelect = 5'd9; cellsIn = 8'hFF; @(negedge clk);
        wrEn = 1'b0; step = 1'b1; @(negedge clk);
        step = 1'b0; en = 1'b1; @(negedge clk);
        checkOutput("enLow busy", 32'(busyT), 32'd0);
        compareGrids("enLow", '0, '0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Step in the same cycle as a write: write lands, step dropped
        resetDut();
        wrEn = 1'b1; step = 1'b1; rowSelect = 5'd6; cellsIn = 8'h0E;
        @(negedge clk);
        wrEn = 1'b0; step = 1'b0;
        checkOutput("collide busy", 32'(busyT), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("collide busyLater", 32'(busyT), 32'd0);
        checkOutput("collide gen", 32'(genT), 32'd0);
        g0 = '0; g0[6] = 8'h0E;
        compareGrids("collide", g0, g0);

        // Write and step during busy are ignored
        runStep(0, 5, bc);
        checkOutput("busyIgnore len", 32'(bc), 32'd33);
        @(negedge clk);
        checkOutput("busyIgnore noRequeue", 32'(busyT), 32'd0);
        checkOutput("busyIgnore gen", 32'(genT), 32'd1);
        g0 = '0; g0[5] = 8'h04; g0[6] = 8'h04; g0[7] = 8'h04;
        compareGrids("busyIgnore", g0, g0);

        // en low for 10 cycles mid-sweep
        resetDut();
        writeRow(5'd10, 8'h02); writeRow(5'd11, 8'h04); writeRow(5'd12, 8'h07);
        g0 = '0; g0[10] = 8'h02; g0[11] = 8'h04; g0[12] = 8'h07;
        runStep(16, 0, bc);
        checkOutput("pause busyLen", 32'(bc), 32'd43);
        checkOutput("pause gen", 32'(genT), 32'd1);
        compareGrids("pause", lifeStep(g0, 1'b1), lifeStep(g0, 1'b0));

        // Glider across the torus seam: 4*ROWS generations returns it home
        resetDut();
        writeRow(5'd30, 8'h02); writeRow(5'd31, 8'h04); writeRow(5'd0, 8'h07);
        g0 = '0; g0[30] = 8'h02; g0[31] = 8'h04; g0[0] = 8'h07;
        gB = g0;
        total = 0;
        for (int s = 0; s < 4 * ROWS; s++) begin
            runStep(0, 0, bc);
            total += bc;
            gB = lifeStep(gB, 1'b0);
        end
        checkOutput("glider busyTotal", 32'(total), 32'(33 * 4 * ROWS));
        checkOutput("glider gen", 32'(genT), 32'(4 * ROWS));
        gT = g0;
        compareGrids("glider", gT, gB);

        // Reset in the middle of a sweep
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (16) @(negedge clk);
        checkOutput("midReset busyBefore", 32'(busyT), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midReset busy", 32'(busyT), 32'd0);
        checkOutput("midReset genT", 32'(genT), 32'd0);
        checkOutput("midReset genB", 32'(genB), 32'd0);
        compareGrids("midReset", '0, '0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
